prefetch_buffer: RTL and testbench



---
 rtl/prefetch_buffer_pkg.sv | 13 +
 rtl/prefetch_buffer_fifo.sv | 45 ++++
 rtl/prefetch_buffer.sv | 114 +++++++++++
 tb/tb_prefetch_buffer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_buffer_pkg;

   // addi x0, x0, 0
   localparam logic [31:0] NOP = 32'h0000_0013;

   // One queued instruction tagged with the PC it was fetched from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/prefetch_buffer_fifo.sv
// Synchronous DEPTH-entry FIFO holding PC-tagged instructions.
// Flush empties the queue and takes priority over a push in the same cycle.
module prefetch_buffer_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         res,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (res || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // Storage array; no reset needed since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push && !flush && !res) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches ahead of decode, queues
// in-order responses with their PCs, and drops stale responses after a redirect.
// Optional feature macro: PREFETCH_BYPASS_EN (response forwarded straight to decode
// when the queue is empty).
module prefetch_buffer
   import prefetch_buffer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        res,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [31:0]   fetch_pc_q, resp_pc_q;
   logic [CW-1:0] outstanding_q, discard_q;
   logic [CW-1:0] outstanding_d;
   logic [CW-1:0] occupancy;
   logic [CW:0]   credit_used;
   logic [31:0]   redirect_aligned;
   logic [63:0]   head_raw;
   entry_t        head;
   entry_t        push_entry;
   logic          accept, resp_keep, queue_valid, push, pop;
`ifdef PREFETCH_BYPASS_EN
   logic          bypass;
`endif

   assign head             = entry_t'(head_raw);
   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

   // Requests in flight plus queued words never exceed DEPTH, so responses always fit.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, occupancy};
   assign imem_req    = !res && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = fetch_pc_q;
   assign accept      = imem_req && imem_ready;

   // A response is kept only if it is not stale and no redirect is flushing this cycle.
   assign resp_keep     = imem_rvalid && (discard_q == '0) && !redirect;
   assign queue_valid   = (occupancy != '0) && !redirect;
   assign outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rvalid);
   assign push_entry    = '{pc: resp_pc_q, instr: imem_rdata};

`ifdef PREFETCH_BYPASS_EN
   assign bypass = resp_keep && (occupancy == '0);
`endif

   // Decode-facing outputs and queue push/pop decisions.
   always_comb begin
      instr_valid = queue_valid;
      instr       = queue_valid ? head.instr : NOP;
      instr_pc    = (occupancy != '0) ? head.pc : resp_pc_q;
      pop         = queue_valid && instr_ready;
      push        = resp_keep;
`ifdef PREFETCH_BYPASS_EN
      if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         instr_pc    = resp_pc_q;
         // Word consumed directly by decode does not occupy a queue slot.
         push        = !instr_ready;
      end
`endif
   end

   // Fetch/response PCs and request bookkeeping; redirect overrides normal advance.
   always_ff @(posedge clk) begin
      if (res) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (redirect) begin
         fetch_pc_q    <= redirect_aligned;
         resp_pc_q     <= redirect_aligned;
         outstanding_q <= outstanding_d;
         // Everything still in flight after this cycle belongs to the old stream.
         discard_q     <= outstanding_d;
      end else begin
         if (accept)    fetch_pc_q <= fetch_pc_q + 32'd4;
         if (resp_keep) resp_pc_q  <= resp_pc_q + 32'd4;
         outstanding_q <= outstanding_d;
         if (imem_rvalid && (discard_q != '0)) discard_q <= discard_q - CW'(1);
      end
   end

   prefetch_buffer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (64)
   ) u_fifo (
      .clk       (clk),
      .res       (res),
      .flush     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_raw),
      .count     (occupancy)
   );

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: constant-vector startup table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_prefetch_buffer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP_W  = 32'h0000_0013;
   localparam int          DEPTH  = 4;

   logic        clk, res;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;

   prefetch_buffer #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .res         (res),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: requests in flight (tagged stale on redirect) and delivered words.
   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int          due;
   } req_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } ins_t;

   typedef struct {
      bit          res;
      bit          rdy;
      bit          irdy;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   req_t        inflight[$];
   ins_t        iq[$];
   logic [31:0] m_fetch_pc;
   int          cyc, last_due;
   int          n_checks, n_fail;

   logic        s_req, s_valid;
   logic [31:0] s_addr, s_instr, s_pc;

   vec_t        tbl[8];

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got %08h expected %08h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, act as the memory, compare at negedge, advance model.
   task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy,
                       input bit irdy, input int lat);
      bit          rv, rv_fresh, e_req, e_valid, taken, empty_before;
      logic [31:0] rdat, e_instr, e_pc;
      req_t        f;
      int          due;
      res         = r;
      redirect    = rd;
      redirect_pc = rpc;
      imem_ready  = rdy;
      instr_ready = irdy;
      if (r) begin
         inflight.delete();
         last_due = cyc;
      end
      rv       = 1'b0;
      rv_fresh = 1'b0;
      rdat     = $urandom();
      if (inflight.size() > 0) begin
         if (inflight[0].due <= cyc) begin
            rv       = 1'b1;
            rdat     = memw(inflight[0].addr);
            rv_fresh = !inflight[0].stale;
         end
      end
      imem_rvalid = rv;
      imem_rdata  = rdat;

      e_req   = !r && !rd && (inflight.size() + iq.size() < DEPTH);
      e_valid = !rd && (iq.size() > 0);
      e_instr = NOP_W;
      e_pc    = 32'h0;
      if (iq.size() > 0) begin
         e_instr = iq[0].word;
         e_pc    = iq[0].pc;
      end
`ifdef PREFETCH_BYPASS_EN
      if (!rd && iq.size() == 0 && rv_fresh) begin
         e_valid = 1'b1;
         e_instr = rdat;
         e_pc    = inflight[0].addr;
      end
`endif

      @(negedge clk);
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = instr_valid;
      s_instr = instr;
      s_pc    = instr_pc;
      check("imem_req", s_req, e_req);
      check("imem_addr", s_addr, m_fetch_pc);
      check("instr_valid", s_valid, e_valid);
      if (e_valid) begin
         check("instr_pc", s_pc, e_pc);
         check("instr", s_instr, e_instr);
      end else begin
         check("instr_nop", s_instr, NOP_W);
      end

      if (r) begin
         iq.delete();
         inflight.delete();
         m_fetch_pc = RST_PC;
      end else begin
         empty_before = (iq.size() == 0);
         taken        = e_valid && irdy;
         if (rd) iq.delete();
         else if (taken && !empty_before) void'(iq.pop_front());
         if (rv) begin
            f = inflight.pop_front();
            if (!rd && !f.stale && !(taken && empty_before)) iq.push_back('{f.addr, rdat});
         end
         if (rd) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fetch_pc = {rpc[31:2], 2'b00};
         end else if (e_req && rdy) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            inflight.push_back('{m_fetch_pc, 1'b0, due});
            last_due   = due;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      logic [31:0] a0;
      bit          found;
      bit          r, rd, rdy, irdy;
      logic [31:0] rpc;

      // Startup vectors: reset, latency 1, consumer always ready.
      tbl[0] = '{1, 1, 1, 0, 32'h100, 0, 32'h100};
      tbl[1] = '{0, 1, 1, 1, 32'h100, 0, 32'h0};
`ifdef PREFETCH_BYPASS_EN
      tbl[2] = '{0, 1, 1, 1, 32'h104, 1, 32'h100};
      tbl[3] = '{0, 1, 1, 1, 32'h108, 1, 32'h104};
      tbl[4] = '{0, 1, 1, 1, 32'h10C, 1, 32'h108};
      tbl[5] = '{0, 1, 1, 1, 32'h110, 1, 32'h10C};
      tbl[6] = '{0, 1, 1, 1, 32'h114, 1, 32'h110};
      tbl[7] = '{0, 1, 1, 1, 32'h118, 1, 32'h114};
`else
      tbl[2] = '{0, 1, 1, 1, 32'h104, 0, 32'h0};
      tbl[3] = '{0, 1, 1, 1, 32'h108, 1, 32'h100};
      tbl[4] = '{0, 1, 1, 1, 32'h10C, 1, 32'h104};
      tbl[5] = '{0, 1, 1, 1, 32'h110, 1, 32'h108};
      tbl[6] = '{0, 1, 1, 1, 32'h114, 1, 32'h10C};
      tbl[7] = '{0, 1, 1, 1, 32'h118, 1, 32'h110};
`endif

      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      last_due = 0;
      m_fetch_pc = RST_PC;
      res = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
      instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].res, 1'b0, 32'h0, tbl[i].rdy, tbl[i].irdy, 1);
         check("tbl_req", s_req, tbl[i].exp_req);
         check("tbl_addr", s_addr, tbl[i].exp_addr);
         check("tbl_valid", s_valid, tbl[i].exp_valid);
         if (tbl[i].exp_valid || tbl[i].res) check("tbl_pc", s_pc, tbl[i].exp_pc);
         if (tbl[i].exp_valid) check("tbl_instr", s_instr, memw(tbl[i].exp_pc));
         else check("tbl_nop", s_instr, NOP_W);
      end

      // Consumer stalls 10 cycles at latency 2: queue fills and requests stop.
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 2);
      check("stall_req_off", s_req, 1'b0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 2);

      // Reset with a full queue.
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 1);
      check("full_valid", s_valid, 1'b1);
      step(1, 0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1, 1);
      check("post_res_valid", s_valid, 1'b0);
      check("post_res_instr", s_instr, NOP_W);
      check("post_res_addr", s_addr, RST_PC);
      step(0, 0, 0, 1, 1, 1);
`ifdef PREFETCH_BYPASS_EN
      check("bypass_same_cycle", s_valid, 1'b1);
`else
      check("no_bypass_latency", s_valid, 1'b0);
`endif

      // Redirect to 0x203 with three requests outstanding.
      step(1, 0, 0, 1, 1, 4);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 4);
      step(0, 1, 32'h203, 1, 1, 4);
      step(0, 0, 0, 1, 1, 1);
      check("redirect_addr", s_addr, 32'h200);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(0, 0, 0, 1, 1, 1);
         if (s_valid) begin
            found = 1'b1;
            check("redirect_first_pc", s_pc, 32'h200);
            check("redirect_first_instr", s_instr, memw(32'h200));
         end
      end
      check("redirect_first_valid", {31'b0, found}, 32'd1);

      // imem_ready low for 5 cycles: address holds until accepted.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      a0 = s_addr;
      check("hold_req", s_req, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 1);
         check("hold_addr", s_addr, a0);
      end
      step(0, 0, 0, 1, 1, 1);
      check("accept_addr", s_addr, a0);
      step(0, 0, 0, 1, 1, 1);
      check("advance_addr", s_addr, a0 + 32'd4);

      // Redirect coinciding with a response and a pop.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
      step(0, 1, 32'h400, 1, 1, 1);
      check("redir_valid_off", s_valid, 1'b0);
      step(0, 0, 0, 1, 1, 1);
      check("redir_queue_empty", s_valid, 1'b0);
      check("redir_new_addr", s_addr, 32'h400);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);

      // Fetch address wraps past the top of memory.
      step(0, 1, 32'hFFFF_FFFA, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      check("wrap_addr0", s_addr, 32'hFFFF_FFF8);
      step(0, 0, 0, 1, 1, 1);
      check("wrap_addr1", s_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 1, 1);
      check("wrap_addr2", s_addr, 32'h0000_0000);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         r    = ($urandom_range(0, 299) == 0);
         rd   = !r && ($urandom_range(0, 19) == 0);
         rpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : $urandom();
         rdy  = ($urandom_range(0, 99) < 70);
         irdy = ($urandom_range(0, 99) < 70);
         step(r, rd, rpc, rdy, irdy, $urandom_range(1, 4));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
